// File: rtl/add_seq_ctrl.sv
// Purpose : multi-word (WORDS x 32-bit) add/subtract sequenced over one external 32-bit adder.
// Latency : START accepted at edge E0; BUSY after E0..E0+WORDS; DONE for one cycle after E0+WORDS.
// Backpr. : START honoured only in IDLE/FIN; START during RUN is dropped, never queued.
//
// Ports:
//   CLK, RST               clock; asynchronous active-high reset
//   START, SUB, A, B       request and operands, sampled together on acceptance
//   ADD_X, ADD_Y, ADD_CIN  drive the shared adder (zero outside RUN)
//   ADD_Z, ADD_COUT        combinational result of the shared adder
//   BUSY, DONE             registered-state handshake status
//   SUM, C_OUT, OVF        result, final carry (SUB: 1 = no borrow), signed overflow
module add_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SUB,
  input  logic [32*WORDS-1:0]   A,
  input  logic [32*WORDS-1:0]   B,
  output logic [31:0]           ADD_X,
  output logic [31:0]           ADD_Y,
  output logic                  ADD_CIN,
  input  logic [31:0]           ADD_Z,
  input  logic                  ADD_COUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [32*WORDS-1:0]   SUM,
  output logic                  C_OUT,
  output logic                  OVF
);

  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    ar;
  logic [W-1:0]    br;
  logic            carry;
  logic            accept;
  logic            last_word;

  // A new request is only taken when no operation is in flight.
  assign accept    = START && ((state == S_IDLE) || (state == S_FIN));
  assign last_word = (idx == IW'(WORDS - 1));

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_RUN;
      S_RUN:   if (last_word) state_nxt = S_FIN;
      S_FIN:   state_nxt = START ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    BUSY    = 1'b0;
    DONE    = 1'b0;
    ADD_X   = 32'd0;
    ADD_Y   = 32'd0;
    ADD_CIN = 1'b0;
    case (state)
      S_RUN: begin
        BUSY    = 1'b1;
        ADD_X   = ar[idx*32 +: 32];
        ADD_Y   = br[idx*32 +: 32];
        ADD_CIN = carry;
      end
      S_FIN:   DONE = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, per-word result capture and inter-word carry.
  // Subtraction is A + ~B + 1, so B is inverted at latch time and the
  // initial carry-in is SUB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ar    <= '0;
      br    <= '0;
      carry <= 1'b0;
      idx   <= '0;
      SUM   <= '0;
      C_OUT <= 1'b0;
      OVF   <= 1'b0;
    end else if (accept) begin
      ar    <= A;
      br    <= SUB ? ~B : B;
      carry <= SUB;
      idx   <= '0;
      SUM   <= '0;
      C_OUT <= 1'b0;
      OVF   <= 1'b0;
    end else if (state == S_RUN) begin
      SUM[idx*32 +: 32] <= ADD_Z;
      carry             <= ADD_COUT;
      if (last_word) begin
        idx   <= '0;
        C_OUT <= ADD_COUT;
        // Same-sign operands (B already inverted for SUB) producing a
        // result of the opposite sign is a signed overflow.
        OVF   <= (ar[W-1] == br[W-1]) && (ADD_Z[31] != ar[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Purpose : self-checking bench for add_seq_ctrl with a behavioural 32-bit adder attached.
// Latency : checks BUSY for WORDS cycles after acceptance, then a single DONE cycle.
// Backpr. : exercises START during RUN (ignored), START held through FIN, and mid-run reset.
module tb_add_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic          CLK;
  logic          RST;
  logic          START;
  logic          SUB;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [31:0]   ADD_X;
  logic [31:0]   ADD_Y;
  logic          ADD_CIN;
  logic [31:0]   ADD_Z;
  logic          ADD_COUT;
  logic          BUSY;
  logic          DONE;
  logic [W-1:0]  SUM;
  logic          C_OUT;
  logic          OVF;

  int n_cmp = 0;
  int n_bad = 0;

  add_seq_ctrl #(.WORDS(WORDS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .SUB      (SUB),
    .A        (A),
    .B        (B),
    .ADD_X    (ADD_X),
    .ADD_Y    (ADD_Y),
    .ADD_CIN  (ADD_CIN),
    .ADD_Z    (ADD_Z),
    .ADD_COUT (ADD_COUT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SUM      (SUM),
    .C_OUT    (C_OUT),
    .OVF      (OVF)
  );

  // External combinational 32-bit adder
  assign {ADD_COUT, ADD_Z} = {1'b0, ADD_X} + {1'b0, ADD_Y} + {32'd0, ADD_CIN};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  // Reference result from plain W-bit arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] t;
    if (!sub) begin
      t  = {1'b0, a} + {1'b0, b};
      co = t[W];
    end else begin
      t  = {1'b0, a} - {1'b0, b};
      co = (a >= b);
    end
    s = t[W-1:0];
    if (!sub) ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    else      ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Carry entering word w: carry out of the low 32*w bits (no-borrow for SUB).
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub, input int w);
    logic [W:0] m;
    logic [W:0] t;
    m = ({{W{1'b0}}, 1'b1} << (32 * w)) - 1;
    if (!sub) begin
      t = ({1'b0, a} & m) + ({1'b0, b} & m);
      return t[32*w];
    end
    return (({1'b0, a} & m) >= ({1'b0, b} & m));
  endfunction

  function automatic logic [31:0] word_of(input logic [W-1:0] v, input int w);
    logic [W-1:0] t;
    t = v >> (32 * w);
    return t[31:0];
  endfunction

  // Present a request at a negedge; returns at the negedge of the first RUN cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    START = 1'b1;
    A     = a;
    B     = b;
    SUB   = sub;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    A     = rand_w();
    B     = rand_w();
    SUB   = 1'($urandom);
  endtask

  // Check the RUN cycles and the DONE cycle of an operation already accepted.
  // poke:  pulse START with junk operands mid-run.
  // chain: hold START with the next operands through FIN; returns in the next op's first RUN cycle.
  task automatic finish(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit poke, input bit chain,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input logic nsub);
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    logic [W-1:0] bx;
    bx = sub ? ~b : b;
    for (int w = 0; w < WORDS; w++) begin
      check("run_busy", W'(BUSY), W'(1));
      check("run_done", W'(DONE), W'(0));
      check("add_x", W'(ADD_X), W'(word_of(a, w)));
      check("add_y", W'(ADD_Y), W'(word_of(bx, w)));
      check("add_cin", W'(ADD_CIN), W'(carry_into(a, b, sub, w)));
      if (poke && w == 1) begin
        START = 1'b1;
        A     = rand_w();
        B     = rand_w();
        SUB   = ~sub;
      end
      if (poke && w == 2) START = 1'b0;
      if (chain && w == WORDS - 1) begin
        START = 1'b1;
        A     = na;
        B     = nb;
        SUB   = nsub;
      end
      @(negedge CLK);
    end
    model(a, b, sub, es, eco, eov);
    check("fin_done", W'(DONE), W'(1));
    check("fin_busy", W'(BUSY), W'(0));
    check("fin_add_x", W'(ADD_X), W'(0));
    check("fin_add_cin", W'(ADD_CIN), W'(0));
    check("sum", SUM, es);
    check("c_out", W'(C_OUT), W'(eco));
    check("ovf", W'(OVF), W'(eov));
    if (chain) begin
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      check("chain_done_off", W'(DONE), W'(0));
    end else begin
      @(negedge CLK);
      check("idle_done", W'(DONE), W'(0));
      check("idle_busy", W'(BUSY), W'(0));
      check("sum_hold", SUM, es);
      check("c_out_hold", W'(C_OUT), W'(eco));
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    issue(a, b, sub);
    finish(a, b, sub, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    RST   = 1'b1;
    START = 1'b0;
    SUB   = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", W'(BUSY), W'(0));
    check("rst_done", W'(DONE), W'(0));
    check("rst_sum", SUM, '0);
    check("rst_c_out", W'(C_OUT), W'(0));
    check("rst_ovf", W'(OVF), W'(0));
    check("rst_add_x", W'(ADD_X), W'(0));
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_nostart_busy", W'(BUSY), W'(0));
    check("idle_nostart_done", W'(DONE), W'(0));

    // Directed cases
    op(W'(1), W'(1), 1'b0);
    op('1, '1, 1'b0);
    op({32'h0, {96{1'b1}}}, W'(1), 1'b0);
    op(W'(5), W'(7), 1'b1);
    op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
    op({1'b1, {(W-1){1'b0}}}, W'(1), 1'b1);
    op(W'(9), W'(9), 1'b1);

    // START pulsed during RUN is ignored
    issue(W'(32'h1234_5678), W'(32'h0000_0001), 1'b0);
    finish(W'(32'h1234_5678), W'(32'h0000_0001), 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    // START held through FIN: back-to-back operations
    issue(W'(100), W'(23), 1'b1);
    finish(W'(100), W'(23), 1'b1, 1'b0, 1'b1, '1, W'(2), 1'b0);
    finish('1, W'(2), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Reset in the second RUN cycle discards the operation
    issue('1, '1, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("mid_rst_busy", W'(BUSY), W'(0));
    check("mid_rst_done", W'(DONE), W'(0));
    check("mid_rst_sum", SUM, '0);
    check("mid_rst_c_out", W'(C_OUT), W'(0));
    check("mid_rst_add_x", W'(ADD_X), W'(0));
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < WORDS + 2; i++) begin
      @(negedge CLK);
      check("post_rst_no_done", W'(DONE), W'(0));
    end
    op(W'(1), W'(1), 1'b0);

    // Randomized operations, some with biased sign bits for overflow coverage
    for (int i = 0; i < 40; i++) begin
      ra = rand_w();
      rb = rand_w();
      rs = 1'($urandom);
      if (i % 4 == 1) rb = ra;
      if (i % 4 == 2) rb = ~ra;
      op(ra, rb, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
